// File: rtl/avalon_cmd_regs.sv
// rtl/avalon_cmd_regs.sv - Avalon-MM command/control register block for N_CH pulse-generator channels
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   avs_address/write/...   Avalon-MM slave (no waitrequest, fixed 1-cycle read latency)
//   busy_i                  per-channel busy, synchronous to clk
//   start_o/stop_o/start_n_o  one-cycle command strobes, one cycle after the CMD write
//   invert_o, n_count_o     level controls straight from CTRL / COUNT
//   irq                     registered level interrupt
module avalon_cmd_regs #(
  parameter int          N_CH     = 4,
  parameter int          DATA_W   = 32,
  parameter int          CNT_W    = 16,
  parameter logic [31:0] BLOCK_ID = 32'h0000_C0DE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        avs_address,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic              avs_read,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  input  logic [N_CH-1:0]   busy_i,
  output logic [N_CH-1:0]   start_o,
  output logic [N_CH-1:0]   stop_o,
  output logic [N_CH-1:0]   start_n_o,
  output logic [N_CH-1:0]   invert_o,
  output logic [CNT_W-1:0]  n_count_o,
  output logic              irq
);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_CMD    = 3'd1;
  localparam logic [2:0] A_COUNT  = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_MASK   = 3'd4;
  localparam logic [2:0] A_ID     = 3'd5;

  logic [N_CH-1:0]   invert_q,   invert_d;
  logic [N_CH-1:0]   enable_q,   enable_d;
  logic [CNT_W-1:0]  count_q,    count_d;
  logic [N_CH-1:0]   irq_mask_q, irq_mask_d;
  logic [N_CH-1:0]   cmd_err_q,  cmd_err_d;
  logic              addr_err_q, addr_err_d;
  logic [N_CH-1:0]   start_q,    start_d;
  logic [N_CH-1:0]   stop_q,     stop_d;
  logic [N_CH-1:0]   start_n_q,  start_n_d;
  logic [DATA_W-1:0] rdata_q,    rdata_d;
  logic              rvalid_q,   rvalid_d;
  logic              irq_q,      irq_d;

  logic [N_CH-1:0]   cmd_err_set, cmd_err_clr;
  logic              addr_err_set, addr_err_clr;
  logic              unmapped;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] id_val;
  logic              unused_wdata;

  // Write data above the widest field is never looked at.
  assign unused_wdata = ^avs_writedata;
  assign id_val       = DATA_W'(BLOCK_ID);
  assign unmapped     = avs_address[2] & avs_address[1];

  // Register value as seen at the read edge (before any same-edge update).
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      A_CTRL: begin
        rd_mux[N_CH-1:0]      = invert_q;
        rd_mux[2*N_CH-1:N_CH] = enable_q;
      end
      A_COUNT:  rd_mux[CNT_W-1:0] = count_q;
      A_STATUS: begin
        rd_mux[N_CH-1:0]      = busy_i;
        rd_mux[2*N_CH-1:N_CH] = cmd_err_q;
        rd_mux[DATA_W-1]      = addr_err_q;
      end
      A_MASK:   rd_mux[N_CH-1:0] = irq_mask_q;
      A_ID:     rd_mux = id_val;
      default:  rd_mux = '0;
    endcase
  end

  always_comb begin
    invert_d     = invert_q;
    enable_d     = enable_q;
    count_d      = count_q;
    irq_mask_d   = irq_mask_q;
    start_d      = '0;
    stop_d       = '0;
    start_n_d    = '0;
    rdata_d      = rdata_q;
    rvalid_d     = 1'b0;
    cmd_err_set  = '0;
    cmd_err_clr  = '0;
    addr_err_clr = 1'b0;

    // A colliding read is dropped and flagged; touching 6-7 either way is flagged.
    addr_err_set = (avs_read & avs_write) | ((avs_read | avs_write) & unmapped);

    if (avs_write) begin
      case (avs_address)
        A_CTRL: begin
          invert_d = avs_writedata[N_CH-1:0];
          enable_d = avs_writedata[2*N_CH-1:N_CH];
        end
        A_CMD: begin
          for (int i = 0; i < N_CH; i++) begin
            if (avs_writedata[N_CH+i]) begin
              // Stop has priority; any start request alongside it is an error.
              if (enable_q[i]) stop_d[i] = 1'b1;
              else             cmd_err_set[i] = 1'b1;
              if (avs_writedata[i] | avs_writedata[2*N_CH+i]) cmd_err_set[i] = 1'b1;
            end else if (avs_writedata[i] | avs_writedata[2*N_CH+i]) begin
              if (!enable_q[i] || busy_i[i]) begin
                cmd_err_set[i] = 1'b1;
              end else if (avs_writedata[2*N_CH+i]) begin
                // start_N wins over plain start; both together is flagged.
                start_n_d[i] = 1'b1;
                if (avs_writedata[i]) cmd_err_set[i] = 1'b1;
              end else begin
                start_d[i] = 1'b1;
              end
            end
          end
        end
        A_COUNT:  count_d    = avs_writedata[CNT_W-1:0];
        A_STATUS: begin
          cmd_err_clr  = avs_writedata[2*N_CH-1:N_CH];
          addr_err_clr = avs_writedata[DATA_W-1];
        end
        A_MASK:   irq_mask_d = avs_writedata[N_CH-1:0];
        default: ;
      endcase
    end

    if (avs_read && !avs_write) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end

    // Set beats clear when both land on the same edge.
    cmd_err_d  = (cmd_err_q & ~cmd_err_clr) | cmd_err_set;
    addr_err_d = (addr_err_q & ~addr_err_clr) | addr_err_set;

    irq_d = (|(cmd_err_q & irq_mask_q)) | addr_err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      invert_q   <= '0;
      enable_q   <= '0;
      count_q    <= '0;
      irq_mask_q <= '0;
      cmd_err_q  <= '0;
      addr_err_q <= 1'b0;
      start_q    <= '0;
      stop_q     <= '0;
      start_n_q  <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      invert_q   <= invert_d;
      enable_q   <= enable_d;
      count_q    <= count_d;
      irq_mask_q <= irq_mask_d;
      cmd_err_q  <= cmd_err_d;
      addr_err_q <= addr_err_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      start_n_q  <= start_n_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      irq_q      <= irq_d;
    end
  end

  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign start_o           = start_q;
  assign stop_o            = stop_q;
  assign start_n_o         = start_n_q;
  assign invert_o          = invert_q;
  assign n_count_o         = count_q;
  assign irq               = irq_q;

endmodule

// File: tb/tb_avalon_cmd_regs.sv
// tb/tb_avalon_cmd_regs.sv - randomized self-checking bench for avalon_cmd_regs
module tb_avalon_cmd_regs;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    avs_address;
  logic          avs_write;
  logic [DW-1:0] avs_writedata;
  logic          avs_read;
  logic [DW-1:0] avs_readdata;
  logic          avs_readdatavalid;
  logic [N-1:0]  busy_i;
  logic [N-1:0]  start_o, stop_o, start_n_o, invert_o;
  logic [CW-1:0] n_count_o;
  logic          irq;

  avalon_cmd_regs #(.N_CH(N), .DATA_W(DW), .CNT_W(CW), .BLOCK_ID(32'h0000_C0DE)) dut (
    .clk(clk), .rst_n(rst_n),
    .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_read(avs_read), .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .busy_i(busy_i), .start_o(start_o), .stop_o(stop_o), .start_n_o(start_n_o),
    .invert_o(invert_o), .n_count_o(n_count_o), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: per-channel state held as plain integers.
  int          m_inv[N], m_en[N], m_err[N], m_mask[N];
  int          m_start[N], m_stop[N], m_sn[N];
  int          m_count, m_aerr, m_rvalid, m_irq;
  logic [31:0] m_rdata;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_inv[i] = 0; m_en[i] = 0; m_err[i] = 0; m_mask[i] = 0;
      m_start[i] = 0; m_stop[i] = 0; m_sn[i] = 0;
    end
    m_count = 0; m_aerr = 0; m_rvalid = 0; m_irq = 0; m_rdata = 0;
  endtask

  function automatic logic [31:0] reg_value(input int a, input logic [N-1:0] busy);
    logic [31:0] v;
    v = 0;
    case (a)
      0: for (int i = 0; i < N; i++) v = v + (m_inv[i] << i) + (m_en[i] << (N + i));
      2: v = m_count;
      3: begin
        v = busy;
        for (int i = 0; i < N; i++) v = v + (m_err[i] << (N + i));
        if (m_aerr != 0) v = v + 32'h8000_0000;
      end
      4: for (int i = 0; i < N; i++) v = v + (m_mask[i] << i);
      5: v = 32'h0000_C0DE;
      default: v = 0;
    endcase
    return v;
  endfunction

  // Apply one bus cycle, advance the model over its clock edge, check at the next negedge.
  task automatic step(input bit wr, input bit rd, input int addr, input logic [31:0] d,
                      input logic [N-1:0] busy);
    int irq_n, aset, want;
    int eset[N];
    logic [N-1:0] e_start, e_stop, e_sn, e_inv;

    avs_write = wr; avs_read = rd; avs_address = addr[2:0]; avs_writedata = d; busy_i = busy;

    irq_n = m_aerr;
    for (int i = 0; i < N; i++) begin
      if (m_err[i] != 0 && m_mask[i] != 0) irq_n = 1;
      eset[i] = 0; m_start[i] = 0; m_stop[i] = 0; m_sn[i] = 0;
    end
    aset = ((wr && rd) || ((wr || rd) && addr >= 6)) ? 1 : 0;

    if (rd && !wr) begin
      m_rvalid = 1;
      m_rdata  = reg_value(addr, busy);
    end else begin
      m_rvalid = 0;
    end

    if (wr) begin
      case (addr)
        0: for (int i = 0; i < N; i++) begin m_inv[i] = d[i]; m_en[i] = d[N+i]; end
        1: for (int i = 0; i < N; i++) begin
          want = (d[i] || d[2*N+i]) ? 1 : 0;
          if (d[N+i]) begin
            if (m_en[i] != 0) m_stop[i] = 1;
            if (m_en[i] == 0 || want != 0) eset[i] = 1;
          end else if (want != 0) begin
            if (m_en[i] == 0 || busy[i]) eset[i] = 1;
            else begin
              if (d[2*N+i]) m_sn[i] = 1; else m_start[i] = 1;
              if (d[i] && d[2*N+i]) eset[i] = 1;
            end
          end
        end
        2: m_count = d[15:0];
        3: begin
          for (int i = 0; i < N; i++) if (d[N+i]) m_err[i] = 0;
          if (d[31]) m_aerr = 0;
        end
        4: for (int i = 0; i < N; i++) m_mask[i] = d[i];
        default: ;
      endcase
    end
    for (int i = 0; i < N; i++) if (eset[i] != 0) m_err[i] = 1;
    if (aset != 0) m_aerr = 1;
    m_irq = irq_n;

    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      e_start[i] = m_start[i][0]; e_stop[i] = m_stop[i][0];
      e_sn[i] = m_sn[i][0]; e_inv[i] = m_inv[i][0];
    end
    chk("start_o", start_o, e_start);
    chk("stop_o", stop_o, e_stop);
    chk("start_n_o", start_n_o, e_sn);
    chk("invert_o", invert_o, e_inv);
    chk("n_count_o", n_count_o, m_count);
    chk("irq", irq, m_irq);
    chk("rvalid", avs_readdatavalid, m_rvalid);
    chk("rdata", avs_readdata, m_rdata);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    int r;
    bit wr, rd;
    logic [31:0] d;
    int a;

    rst_n = 1'b0; avs_write = 0; avs_read = 0; avs_address = 0; avs_writedata = 0; busy_i = 0;
    model_reset();
    #2;
    chk("reset_outputs", {start_o, stop_o, start_n_o, invert_o, n_count_o, irq,
                          avs_readdatavalid, avs_readdata}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Enabled start
    step(1, 0, 0, 32'h0F0, 0);
    step(1, 0, 1, 32'h001, 0);
    chk("tp_start", start_o, 4'b0001);
    idle();
    chk("tp_start_one_cycle", start_o, 4'b0000);

    // Busy rejection with masked interrupt, then W1C
    step(1, 0, 4, 32'h2, 0);
    step(1, 0, 1, 32'h002, 4'b0010);
    chk("tp_busy_nostrobe", start_o, 4'b0000);
    step(0, 1, 3, 0, 0);
    chk("tp_irq_set", irq, 1);
    chk("tp_err_bit", avs_readdata[5], 1);
    step(1, 0, 3, 32'h20, 0);
    idle();
    chk("tp_irq_clear", irq, 0);

    // Start + stop conflict
    step(1, 0, 1, 32'h011, 0);
    chk("tp_conflict", {stop_o, start_o}, 8'h10);

    // start_N and invert
    step(1, 0, 2, 32'h100, 0);
    step(1, 0, 1, 32'h100, 0);
    chk("tp_start_n", start_n_o, 4'b0001);
    chk("tp_count", n_count_o, 16'h0100);
    step(1, 0, 0, 32'h0F5, 0);
    chk("tp_invert", invert_o, 4'b0101);

    // Address errors
    step(1, 0, 6, 32'hFFFF_FFFF, 0);
    idle();
    chk("tp_addr_irq", irq, 1);
    step(0, 1, 7, 0, 0);
    chk("tp_unmapped_read", {avs_readdatavalid, avs_readdata}, 33'h1_0000_0000);
    step(1, 1, 0, 32'h0F5, 0);
    chk("tp_rw_drop", avs_readdatavalid, 0);
    step(1, 1, 3, 32'h8000_0000, 0);
    step(0, 1, 3, 0, 0);
    chk("tp_set_wins", avs_readdata[31], 1);
    step(0, 1, 5, 0, 0);
    chk("tp_id", avs_readdata, 32'h0000_C0DE);

    // Reset while a start strobe is in flight
    avs_write = 1; avs_read = 0; avs_address = 3'd1; avs_writedata = 32'h1; busy_i = 0;
    @(posedge clk);
    #1;
    chk("rst_pre_strobe", start_o, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {start_o, stop_o, start_n_o, invert_o, n_count_o, irq,
                            avs_readdatavalid, avs_readdata}, 0);
    avs_write = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 0, 0, 0);
    step(0, 1, 2, 0, 0);
    step(0, 1, 3, 0, 0);
    step(0, 1, 5, 0, 0);
    chk("rst_id", avs_readdata, 32'h0000_C0DE);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      r  = $urandom_range(0, 99);
      wr = (r < 40) || (r >= 95);
      rd = (r >= 40 && r < 80) || (r >= 95);
      a  = $urandom_range(0, 7);
      d  = $urandom;
      if (a == 1 && $urandom_range(0, 1) == 1) d = 32'h1 << $urandom_range(0, 11);
      if (a == 3 && $urandom_range(0, 3) != 0) d = 0;
      step(wr, rd, a, d, N'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/avalon_cmd_regs.md
Name: avalon_cmd_regs

Overview:
Parametrised Avalon-MM slave register block that turns CPU writes into per-channel command strobes (start, stop, start_N) and level controls (pulse invert) for N_CH pulse-generator channels.
Adds channel enables, a start_N count register, busy-qualified command checking, sticky W1C error status, a fixed-latency read path with readdatavalid, and an interrupt.
Sits between the Avalon interconnect and the pulse-generator channels.

Parameters:
N_CH, 4, number of channels (1..8).
DATA_W, 32, Avalon data width; must be >= 3*N_CH and >= CNT_W, and 2*N_CH < DATA_W-1.
CNT_W, 16, width of the start_N count register.
BLOCK_ID, 32'h0000_C0DE, constant returned by the ID register (truncated to DATA_W).

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
avs_address  in  3  word address.
avs_write  in  1  write strobe.
avs_writedata  in  DATA_W  write data.
avs_read  in  1  read strobe.
avs_readdata  out  DATA_W  read data, valid when avs_readdatavalid=1.
avs_readdatavalid  out  1  one-cycle read-return strobe.
busy_i  in  N_CH  channel busy, synchronous to clk.
start_o  out  N_CH  one-cycle start strobes.
stop_o  out  N_CH  one-cycle stop strobes.
start_n_o  out  N_CH  one-cycle start-N strobes.
invert_o  out  N_CH  pulse-invert level per channel.
n_count_o  out  CNT_W  pulse count for start_N, equal to the COUNT register.
irq  out  1  level interrupt.

Behaviour:
- Reset (rst_n=0, async): all registers 0, all strobes 0, avs_readdatavalid=0, avs_readdata=0, irq=0. A command strobe in flight when reset asserts is dropped.
- No waitrequest: every access is accepted in its cycle.
- Register map (word address):
  - 0 CTRL RW: [N_CH-1:0] invert, [2N_CH-1:N_CH] enable; other bits read 0.
  - 1 CMD WO: [N_CH-1:0] start, [2N_CH-1:N_CH] stop, [3N_CH-1:2N_CH] start_N. Reads return 0.
  - 2 COUNT RW: [CNT_W-1:0].
  - 3 STATUS: [N_CH-1:0] busy_i live (RO); [2N_CH-1:N_CH] cmd_err sticky (W1C); bit DATA_W-1 addr_err sticky (W1C).
  - 4 IRQ_MASK RW: [N_CH-1:0] mask for cmd_err.
  - 5 ID RO: BLOCK_ID.
  - 6-7 unmapped.
- Writes take effect on the clock edge where avs_write=1. invert_o and n_count_o follow CTRL and COUNT with no extra register stage.
- CMD write, evaluated per channel i on the same edge using busy_i sampled that cycle:
  - stop bit set: stop_o[i]=1 for exactly the next cycle if enable[i]=1; otherwise cmd_err[i] is set.
  - start or start_N set with stop also set: stop wins, start/start_N suppressed, cmd_err[i] set.
  - start or start_N set while enable[i]=0 or busy_i[i]=1: no strobe, cmd_err[i] set.
  - start and start_N both set: start_n_o only, cmd_err[i] set.
  - otherwise the requested strobe is asserted for exactly one cycle, one cycle after the write.
  - Back-to-back CMD writes give back-to-back strobes.
- Writes to ID, STATUS[RO bits] or CMD bits above 3N_CH are ignored. A write to address 6-7 sets addr_err.
- STATUS W1C: writing 1 clears the bit. If an error sets in the same cycle as its clear, set wins.
- Reads: avs_readdatavalid=1 exactly one cycle after avs_read, with avs_readdata the register value at the read edge. Address 6-7 returns 0 and sets addr_err. avs_readdata holds its last value when not valid.
- avs_read and avs_write asserted in the same cycle: the write executes, the read is dropped (no readdatavalid), and addr_err is set.
- irq = |(cmd_err & IRQ_MASK) | addr_err, registered (one-cycle delay from the error edge).

Test Plan:
- Reset: assert rst_n=0 mid-CMD write -> all outputs 0 immediately; after release, CTRL/COUNT/STATUS read back 0 and ID reads 32'h0000_C0DE with readdatavalid 1 cycle after read.
- Enabled start: write CTRL=0x0F0, then CMD=0x001 with busy_i=0 -> start_o=4'b0001 for exactly 1 cycle, 1 cycle after the write; cmd_err stays 0.
- Busy/disabled rejection: busy_i[1]=1, write CMD=0x002 -> no strobe, STATUS[5]=1; with IRQ_MASK=0x2, irq=1 next cycle; write STATUS=0x20 -> bit clears, irq falls.
- Conflict: write CMD=0x011 (start+stop ch0) -> stop_o[0] pulses, start_o=0, STATUS[4]=1.
- start_N: write COUNT=0x0100, then CMD=0x100 -> start_n_o[0] pulses, n_count_o=0x0100; CTRL=0x0F5 -> invert_o=4'b0101.
- Address errors: write to address 6 -> STATUS[31]=1 and irq=1; read address 7 -> readdata 0 with valid; simultaneous read+write -> no readdatavalid, addr_err set; W1C in the same cycle as a new error leaves the bit set.
